// File: rtl/gam_node_memory_pkg.sv
// Shared types and constants for the GAM node memory: operation codes,
// field-mask bit positions, FSM states and default-sized record types.
// No ports; imported by gam_node_memory and gam_node_memory_ctrl.
package gam_node_memory_pkg;

  typedef enum logic [1:0] {
    OP_READ      = 2'd0,
    OP_WRITE     = 2'd1,
    OP_APPEND    = 2'd2,
    OP_CLEAR_ALL = 2'd3
  } mem_op_t;

  // Older learning/classification code still speaks plain read/write.
  typedef enum logic {
    RD_WR_READ  = 1'b0,
    RD_WR_WRITE = 1'b1
  } rd_wr_t;

  // Bit positions inside the 5-bit field mask {M,T,W,C,X}.
  localparam int FLD_X = 0;
  localparam int FLD_C = 1;
  localparam int FLD_W = 2;
  localparam int FLD_T = 3;
  localparam int FLD_M = 4;

  // Record shapes at the default geometry, for software-facing users.
  localparam int REC_DIM    = 4;
  localparam int REC_ELEM_W = 16;
  localparam int REC_SCAL_W = 32;
  localparam int REC_NODES  = 16;

  typedef struct packed {
    logic [REC_DIM*REC_ELEM_W-1:0] x;
    logic [REC_DIM*REC_ELEM_W-1:0] w;
    logic [REC_SCAL_W-1:0]         th;
    logic [REC_SCAL_W-1:0]         m;
  } node_rec_t;

  typedef struct packed {
    logic [REC_SCAL_W-1:0]         name;
    logic [$clog2(REC_NODES):0]    count;
  } class_rec_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/gam_node_memory_ctrl.sv
// Control path: request acceptance, IDLE/CLEAR sweep FSM, per-class node
// counts, range/full checks and registered response status (1-cycle latency).
// Ports: req_valid/req_ready/op/cls/node in; rsp_* status out; node_wr,
// wr_node, clr, clr_idx, load, rd_hit steer the storage in the top.
module gam_node_memory_ctrl
  import gam_node_memory_pkg::*;
#(
  parameter int NUM_CLASSES     = 8,
  parameter int NODES_PER_CLASS = 16,
  parameter int CW              = 3,
  parameter int NW              = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  mem_op_t       op,
  input  logic [CW-1:0] cls,
  input  logic [NW-1:0] node,
  output logic          rsp_valid,
  output logic          rsp_err,
  output logic [NW-1:0] rsp_node,
  output logic [NW:0]   rsp_count,
  output logic          node_wr,
  output logic [NW-1:0] wr_node,
  output logic          clr,
  output logic [CW-1:0] clr_idx,
  output logic          load,
  output logic          rd_hit
);

  ctrl_state_t   state_q, state_d;
  logic [CW-1:0] clr_idx_q, clr_idx_d;
  logic [NW:0]   cnt_q [NUM_CLASSES];

  logic          fire, cls_ok, node_ok, full, err, clear_done, cnt_upd;
  logic [NW:0]   cur_cnt, new_cnt;

  assign fire    = req_valid && req_ready;
  // Compared one bit wider so non-power-of-2 class counts are caught.
  assign cls_ok  = {1'b0, cls} < (CW+1)'(NUM_CLASSES);
  assign cur_cnt = cls_ok ? cnt_q[cls] : '0;
  assign node_ok = {1'b0, node} < cur_cnt;
  assign full    = cur_cnt == (NW+1)'(NODES_PER_CLASS);

  always_comb begin
    err     = 1'b0;
    node_wr = 1'b0;
    cnt_upd = 1'b0;
    rd_hit  = 1'b0;
    wr_node = node;
    new_cnt = cur_cnt;
    case (op)
      OP_READ: begin
        err    = !cls_ok || !node_ok;
        rd_hit = !err;
      end
      OP_WRITE: begin
        err     = !cls_ok || !node_ok;
        node_wr = fire && !err;
      end
      OP_APPEND: begin
        err = !cls_ok || full;
        // Nothing is allocated on a rejected append, so report slot 0.
        wr_node = err ? '0 : cur_cnt[NW-1:0];
        if (!err) begin
          new_cnt = cur_cnt + 1'b1;
          node_wr = fire;
          cnt_upd = fire;
        end
      end
      OP_CLEAR_ALL: begin
        err = 1'b0;
      end
      default: begin
        err = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    req_ready  = 1'b0;
    clr        = 1'b0;
    clear_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid && op == OP_CLEAR_ALL) begin
          state_d   = ST_CLEAR;
          clr_idx_d = '0;
        end
      end
      ST_CLEAR: begin
        clr = 1'b1;
        if (clr_idx_q == CW'(NUM_CLASSES-1)) begin
          state_d    = ST_IDLE;
          clear_done = 1'b1;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign clr_idx = clr_idx_q;
  // A clear sweep answers only once its last class is zeroed.
  assign load    = (fire && op != OP_CLEAR_ALL) || clear_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CLASSES; i++) cnt_q[i] <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_node  <= '0;
      rsp_count <= '0;
    end else begin
      if (clr)          cnt_q[clr_idx_q] <= '0;
      else if (cnt_upd) cnt_q[cls]       <= new_cnt;
      rsp_valid <= load;
      if (clear_done) begin
        rsp_err   <= 1'b0;
        rsp_node  <= '0;
        rsp_count <= '0;
      end else if (load) begin
        rsp_err   <= err;
        rsp_node  <= wr_node;
        rsp_count <= new_cnt;
      end
    end
  end

endmodule

// File: rtl/gam_node_memory.sv
// GAM node memory: per-class name and per-node X/W/Th/M storage with
// READ/WRITE/APPEND/CLEAR_ALL requests; responses one cycle after accept.
// Ports: req_valid_i/req_ready_o handshake (ready low only during the
// clear sweep), op/field mask/class/node/data in; rsp_* and read data out.
module gam_node_memory
  import gam_node_memory_pkg::*;
#(
  parameter int NUM_CLASSES     = 8,
  parameter int NODES_PER_CLASS = 16,
  parameter int DIM             = 4,
  parameter int ELEM_W          = 16,
  parameter int SCAL_W          = 32
) (
  input  logic                               clk_i,
  input  logic                               rst_n_i,
  input  logic                               req_valid_i,
  output logic                               req_ready_o,
  input  mem_op_t                            op_i,
  input  logic [4:0]                         fld_en_i,
  input  logic [$clog2(NUM_CLASSES)-1:0]     class_i,
  input  logic [$clog2(NODES_PER_CLASS)-1:0] node_i,
  input  logic [DIM*ELEM_W-1:0]              X_i,
  input  logic [DIM*ELEM_W-1:0]              W_i,
  input  logic [SCAL_W-1:0]                  class_name_i,
  input  logic [SCAL_W-1:0]                  Th_i,
  input  logic [SCAL_W-1:0]                  M_i,
  output logic                               rsp_valid_o,
  output logic                               rsp_err_o,
  output logic [$clog2(NODES_PER_CLASS)-1:0] rsp_node_o,
  output logic [DIM*ELEM_W-1:0]              X_o,
  output logic [DIM*ELEM_W-1:0]              W_o,
  output logic [SCAL_W-1:0]                  class_name_o,
  output logic [SCAL_W-1:0]                  Th_o,
  output logic [SCAL_W-1:0]                  M_o,
  output logic [$clog2(NODES_PER_CLASS):0]   count_o
);

  localparam int CW = $clog2(NUM_CLASSES);
  localparam int NW = $clog2(NODES_PER_CLASS);
  localparam int VW = DIM*ELEM_W;

  logic [VW-1:0]     x_mem    [NUM_CLASSES][NODES_PER_CLASS];
  logic [VW-1:0]     w_mem    [NUM_CLASSES][NODES_PER_CLASS];
  logic [SCAL_W-1:0] th_mem   [NUM_CLASSES][NODES_PER_CLASS];
  logic [SCAL_W-1:0] m_mem    [NUM_CLASSES][NODES_PER_CLASS];
  logic [SCAL_W-1:0] name_mem [NUM_CLASSES];

  logic          node_wr, clr, load, rd_hit;
  logic [NW-1:0] wr_node;
  logic [CW-1:0] clr_idx;

  gam_node_memory_ctrl #(
    .NUM_CLASSES     (NUM_CLASSES),
    .NODES_PER_CLASS (NODES_PER_CLASS),
    .CW              (CW),
    .NW              (NW)
  ) u_ctrl (
    .clk       (clk_i),
    .rst_n     (rst_n_i),
    .req_valid (req_valid_i),
    .req_ready (req_ready_o),
    .op        (op_i),
    .cls       (class_i),
    .node      (node_i),
    .rsp_valid (rsp_valid_o),
    .rsp_err   (rsp_err_o),
    .rsp_node  (rsp_node_o),
    .rsp_count (count_o),
    .node_wr   (node_wr),
    .wr_node   (wr_node),
    .clr       (clr),
    .clr_idx   (clr_idx),
    .load      (load),
    .rd_hit    (rd_hit)
  );

  // Storage is deliberately not reset; node counts gate every access.
  // node_wr and clr are mutually exclusive (clr only outside IDLE).
  always_ff @(posedge clk_i) begin
    if (node_wr) begin
      if (fld_en_i[FLD_X]) x_mem[class_i][wr_node]  <= X_i;
      if (fld_en_i[FLD_W]) w_mem[class_i][wr_node]  <= W_i;
      if (fld_en_i[FLD_T]) th_mem[class_i][wr_node] <= Th_i;
      if (fld_en_i[FLD_M]) m_mem[class_i][wr_node]  <= M_i;
      if (fld_en_i[FLD_C]) name_mem[class_i]        <= class_name_i;
    end
    if (clr) name_mem[clr_idx] <= '0;
  end

  // Read data sampled at accept, so a write committed on the previous
  // edge is already visible. Non-read responses carry zero data.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      X_o          <= '0;
      W_o          <= '0;
      class_name_o <= '0;
      Th_o         <= '0;
      M_o          <= '0;
    end else if (load) begin
      X_o          <= (rd_hit && fld_en_i[FLD_X]) ? x_mem[class_i][node_i]  : '0;
      W_o          <= (rd_hit && fld_en_i[FLD_W]) ? w_mem[class_i][node_i]  : '0;
      Th_o         <= (rd_hit && fld_en_i[FLD_T]) ? th_mem[class_i][node_i] : '0;
      M_o          <= (rd_hit && fld_en_i[FLD_M]) ? m_mem[class_i][node_i]  : '0;
      class_name_o <= (rd_hit && fld_en_i[FLD_C]) ? name_mem[class_i]       : '0;
    end
  end

endmodule

// File: tb/tb_gam_node_memory.sv
// Scoreboard bench for gam_node_memory: requests push expected responses,
// a monitor thread pops and compares on every rsp_valid pulse.
module tb_gam_node_memory;
  import gam_node_memory_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  mem_op_t     op;
  logic [4:0]  fld_en;
  logic [2:0]  cls;
  logic [3:0]  node;
  logic [63:0] x_in, w_in;
  logic [31:0] name_in, th_in, m_in;
  logic        rsp_valid, rsp_err;
  logic [3:0]  rsp_node;
  logic [63:0] x_out, w_out;
  logic [31:0] name_out, th_out, m_out;
  logic [4:0]  count;

  gam_node_memory dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .op_i         (op),
    .fld_en_i     (fld_en),
    .class_i      (cls),
    .node_i       (node),
    .X_i          (x_in),
    .W_i          (w_in),
    .class_name_i (name_in),
    .Th_i         (th_in),
    .M_i          (m_in),
    .rsp_valid_o  (rsp_valid),
    .rsp_err_o    (rsp_err),
    .rsp_node_o   (rsp_node),
    .X_o          (x_out),
    .W_o          (w_out),
    .class_name_o (name_out),
    .Th_o         (th_out),
    .M_o          (m_out),
    .count_o      (count)
  );

  typedef struct packed {
    logic        err;
    logic [3:0]  node;
    logic [4:0]  cnt;
    logic        chk;
    logic [63:0] x;
    logic [63:0] w;
    logic [31:0] name;
    logic [31:0] th;
    logic [31:0] m;
  } exp_t;

  exp_t exp_q [$];
  int   checks;
  int   errors;

  localparam logic [63:0] V1 = {16'd4, 16'd3, 16'd2, 16'd1};
  localparam logic [63:0] V2 = {16'd40, 16'd30, 16'd20, 16'd10};
  localparam logic [63:0] V3 = 64'hDEAD_BEEF_0000_1111;
  localparam logic [31:0] N2 = 32'hCAFE_0002;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic exp_t ex(input logic err, input logic [3:0] nd, input logic [4:0] cnt,
                              input logic chk, input logic [63:0] x, input logic [63:0] w,
                              input logic [31:0] nm, input logic [31:0] th, input logic [31:0] m);
    exp_t e;
    e.err = err; e.node = nd; e.cnt = cnt; e.chk = chk;
    e.x = x; e.w = w; e.name = nm; e.th = th; e.m = m;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  // Issues one request for one cycle; expectation pushed only if push=1.
  task automatic send(input mem_op_t o, input logic [4:0] f, input logic [2:0] c,
                      input logic [3:0] n, input logic [63:0] x, input logic [63:0] w,
                      input logic [31:0] nm, input logic [31:0] th, input logic [31:0] m,
                      input bit push, input exp_t e);
    op = o; fld_en = f; cls = c; node = n;
    x_in = x; w_in = w; name_in = nm; th_in = th; m_in = m;
    req_valid = 1'b1;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (o != OP_CLEAR_ALL) chk("rsp_latency", 64'(rsp_valid), 64'd1);
  endtask

  initial begin
    int lowcnt;
    exp_t z;
    checks = 0; errors = 0;
    rst_n = 1'b0; req_valid = 1'b0; op = OP_READ; fld_en = '0; cls = '0; node = '0;
    x_in = '0; w_in = '0; name_in = '0; th_in = '0; m_in = '0;
    z = ex(1'b0, 4'd0, 5'd0, 1'b0, '0, '0, '0, '0, '0);

    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n && rsp_valid) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rsp err=%0d node=%0d cnt=%0d", rsp_err, rsp_node, count);
          end else begin
            e = exp_q.pop_front();
            if (rsp_err !== e.err || rsp_node !== e.node || count !== e.cnt ||
                (e.chk && (x_out !== e.x || w_out !== e.w || name_out !== e.name ||
                           th_out !== e.th || m_out !== e.m))) begin
              errors++;
              $display("FAIL rsp got err=%0d node=%0d cnt=%0d x=%h w=%h name=%h th=%0d m=%0d want err=%0d node=%0d cnt=%0d x=%h w=%h name=%h th=%0d m=%0d",
                       rsp_err, rsp_node, count, x_out, w_out, name_out, th_out, m_out,
                       e.err, e.node, e.cnt, e.x, e.w, e.name, e.th, e.m);
            end
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", 64'(req_ready), 64'd1);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_err", 64'(rsp_err), 64'd0);
    chk("reset_x", x_out, 64'd0);
    chk("reset_th", 64'(th_out), 64'd0);
    chk("reset_count", 64'(count), 64'd0);
    @(posedge clk); #1;

    // Empty memory: read must be rejected with zero data.
    send(OP_READ, 5'h1F, 3'd0, 4'd0, '0, '0, '0, '0, '0, 1, ex(1, 0, 0, 1, '0, '0, '0, '0, '0));

    // Three appends to class 2, all fields.
    for (int i = 0; i < 3; i++)
      send(OP_APPEND, 5'h1F, 3'd2, 4'd9, V1, V2, N2, 32'd100, 32'd7, 1,
           ex(0, 4'(i), 5'(i+1), 0, '0, '0, '0, '0, '0));
    send(OP_READ, 5'h1F, 3'd2, 4'd1, '0, '0, '0, '0, '0, 1, ex(0, 1, 3, 1, V1, V2, N2, 32'd100, 32'd7));

    // Threshold-only write, then read straight after.
    send(OP_WRITE, 5'b01000, 3'd2, 4'd1, V3, V3, 32'h1234, 32'd55, 32'd99, 1, ex(0, 1, 3, 0, '0, '0, '0, '0, '0));
    send(OP_READ, 5'h1F, 3'd2, 4'd1, '0, '0, '0, '0, '0, 1, ex(0, 1, 3, 1, V1, V2, N2, 32'd55, 32'd7));
    send(OP_READ, 5'b00101, 3'd2, 4'd1, '0, '0, '0, '0, '0, 1, ex(0, 1, 3, 1, V1, V2, '0, '0, '0));

    // Node beyond count.
    send(OP_READ, 5'h1F, 3'd2, 4'd3, '0, '0, '0, '0, '0, 1, ex(1, 3, 3, 1, '0, '0, '0, '0, '0));
    send(OP_WRITE, 5'h1F, 3'd2, 4'd3, V3, V3, 32'h1, 32'd1, 32'd1, 1, ex(1, 3, 3, 0, '0, '0, '0, '0, '0));
    send(OP_READ, 5'b01000, 3'd2, 4'd2, '0, '0, '0, '0, '0, 1, ex(0, 2, 3, 1, '0, '0, '0, 32'd100, '0));

    // Fill class 5, then overflow.
    for (int i = 0; i < 16; i++)
      send(OP_APPEND, 5'b00001, 3'd5, 4'd0, 64'(100 + i), '0, '0, '0, '0, 1,
           ex(0, 4'(i), 5'(i+1), 0, '0, '0, '0, '0, '0));
    send(OP_APPEND, 5'b00001, 3'd5, 4'd0, V3, '0, '0, '0, '0, 1, ex(1, 0, 16, 0, '0, '0, '0, '0, '0));
    send(OP_READ, 5'b00001, 3'd5, 4'd15, '0, '0, '0, '0, '0, 1, ex(0, 15, 16, 1, 64'd115, '0, '0, '0, '0));
    send(OP_READ, 5'b00001, 3'd5, 4'd0, '0, '0, '0, '0, '0, 1, ex(0, 0, 16, 1, 64'd100, '0, '0, '0, '0));

    // Empty mask still allocates.
    send(OP_APPEND, 5'b00000, 3'd3, 4'd0, V3, V3, 32'h5, 32'd5, 32'd5, 1, ex(0, 0, 1, 0, '0, '0, '0, '0, '0));
    send(OP_READ, 5'b00000, 3'd3, 4'd0, '0, '0, '0, '0, '0, 1, ex(0, 0, 1, 1, '0, '0, '0, '0, '0));

    // Clear sweep: ready low for 8 cycles, pulse as ready returns.
    send(OP_CLEAR_ALL, 5'h1F, 3'd2, 4'd0, '0, '0, '0, '0, '0, 1, ex(0, 0, 0, 1, '0, '0, '0, '0, '0));
    lowcnt = 0;
    while (!req_ready && lowcnt < 100) begin
      lowcnt++;
      @(posedge clk); #1;
    end
    chk("clear_ready_low_cycles", 64'(lowcnt), 64'd8);
    chk("clear_rsp_pulse", 64'(rsp_valid), 64'd1);
    send(OP_READ, 5'h1F, 3'd2, 4'd0, '0, '0, '0, '0, '0, 1, ex(1, 0, 0, 1, '0, '0, '0, '0, '0));
    send(OP_READ, 5'h1F, 3'd5, 4'd0, '0, '0, '0, '0, '0, 1, ex(1, 0, 0, 1, '0, '0, '0, '0, '0));
    send(OP_APPEND, 5'b00000, 3'd2, 4'd0, '0, '0, '0, '0, '0, 1, ex(0, 0, 1, 0, '0, '0, '0, '0, '0));
    send(OP_READ, 5'b00010, 3'd2, 4'd0, '0, '0, '0, '0, '0, 1, ex(0, 0, 1, 1, '0, '0, '0, '0, '0));

    // Reset in the middle of a sweep: no response may appear.
    send(OP_APPEND, 5'b00000, 3'd7, 4'd0, '0, '0, '0, '0, '0, 1, ex(0, 0, 1, 0, '0, '0, '0, '0, '0));
    send(OP_CLEAR_ALL, 5'h00, 3'd0, 4'd0, '0, '0, '0, '0, '0, 0, z);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midclr_reset_ready", 64'(req_ready), 64'd1);
    chk("midclr_reset_rsp_valid", 64'(rsp_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("midclr_ready_after", 64'(req_ready), 64'd1);
    send(OP_READ, 5'h1F, 3'd7, 4'd0, '0, '0, '0, '0, '0, 1, ex(1, 0, 0, 1, '0, '0, '0, '0, '0));

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gam_node_memory.md
# gam_node_memory

Clocked, parametrised successor to the GAM memory layer: holds per-class node records (X vector, W vector, threshold Th, count M) plus a per-class name and node-occupancy counter. Requests arrive through a valid/ready handshake and responses return with fixed one-cycle latency. Adds node allocation (APPEND), per-field write masks, range/full error reporting and a multi-cycle CLEAR_ALL sweep. Sits between the GAM learning/classification controllers and storage.

## Interface
Parameters:
- NUM_CLASSES, 8, number of classes
- NODES_PER_CLASS, 16, node slots per class
- DIM, 4, elements per X/W vector
- ELEM_W, 16, bits per vector element
- SCAL_W, 32, width of Th, M, class name

Ports (CW = $clog2(NUM_CLASSES), NW = $clog2(NODES_PER_CLASS)):
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when high with req_valid_i
- op_i  in  MEM_OP_T  READ, WRITE, APPEND, CLEAR_ALL
- fld_en_i  in  5  field mask {M,T,W,C,X}, bit0 = X
- class_i  in  CW  class index
- node_i  in  NW  node index (ignored by APPEND, CLEAR_ALL)
- X_i, W_i  in  DIM*ELEM_W  vectors
- class_name_i, Th_i, M_i  in  SCAL_W  scalars
- rsp_valid_o  out  1  response pulse
- rsp_err_o  out  1  request rejected
- rsp_node_o  out  NW  node index used/allocated
- X_o, W_o  out  DIM*ELEM_W  read data
- class_name_o, Th_o, M_o  out  SCAL_W  read data
- count_o  out  NW+1  occupancy of class_i of the responded request

## Operation
- Storage: per class, name + count; per node, X, W, Th, M. Only counts, FSM and outputs are reset; arrays are not.
- READ: fields with fld_en_i set are returned; disabled fields return 0. node_i >= count -> rsp_err_o=1, all data 0.
- WRITE: enabled fields of node (class_i,node_i) written; C writes class name of class_i. node_i >= count -> err, no write.
- APPEND: if count < NODES_PER_CLASS, write enabled fields to node index = count, rsp_node_o = that index, count++. Full -> err, no write, count unchanged.
- CLEAR_ALL: FSM IDLE -> CLEAR; in CLEAR zero one class count (and name) per cycle, index 0..NUM_CLASSES-1; after last, one response pulse, back to IDLE.
- class_i >= NUM_CLASSES (non-power-of-2) -> err on any op except CLEAR_ALL.
- fld_en_i = 0 on WRITE/APPEND: legal; APPEND still allocates.

## Timing
- Reset: state IDLE, all counts 0, req_ready_o=1, rsp_valid_o=0, rsp_err_o=0, all data outputs 0.
- Accept on rising edge with req_valid_i && req_ready_o; writes/count updates commit at that edge.
- rsp_valid_o high exactly one cycle, the cycle after accept; data outputs hold until next response.
- req_ready_o = (state==IDLE); back-to-back requests at 1/cycle; no response backpressure.
- Read accepted the cycle after a write to the same node returns the new data.
- CLEAR_ALL: req_ready_o low NUM_CLASSES cycles; rsp_valid_o one cycle after last class cleared.
- Reset mid-CLEAR: immediate return to IDLE, counts 0, no response.

## Structure
- GAM_package: MEM_OP_T enum, field-bit constants (FLD_X..FLD_M), node_rec_T and class_rec_T parametrised via localparams there; RD_WR_T retained for legacy users.
- One sub-module: gam_node_memory_ctrl (FSM, counts, range/full checks); storage arrays in top.

## Test plan
- Reset then READ class 0 node 0 -> rsp_err_o=1, count_o=0, data 0.
- APPEND class 2 X=1,2,3,4 Th=100 three times -> rsp_node_o 0,1,2; count_o 3; READ node 1 returns X=1,2,3,4, Th=100.
- WRITE class 2 node 1 mask T only Th=55, then READ all fields -> Th=55, X unchanged.
- 16 APPENDs to class 5 then 17th -> err=1, count_o=16, no data change.
- CLEAR_ALL with NUM_CLASSES=8 -> req_ready_o low 8 cycles, single rsp pulse, subsequent READ any class errs.
- Assert rst_n_i mid-CLEAR_ALL -> outputs reset immediately, no response pulse, req_ready_o=1 after release.
